// File: rtl/modexp_engine.sv
// Montgomery modular-exponentiation engine: r = m^e mod n.
// Radix-2 bit-serial Montgomery product shared by the MAP, SQR, MUL and
// POST phases, driven by an MSB-first square-and-multiply scan of e.
module modexp_engine #(
  parameter int unsigned BITS = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [BITS-1:0] m,
  input  logic [BITS-1:0] e,
  input  logic [BITS-1:0] n,
  output logic [BITS-1:0] r,
  output logic            done,
  output logic            busy,
  output logic            err
);

  localparam int unsigned TW = BITS + 2;
  localparam int unsigned CW = $clog2(2 * BITS + 1);
  localparam int unsigned IW = $clog2(BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_PRE,
    S_MAP,
    S_SQR,
    S_MUL,
    S_POST,
    S_DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] m_r;
  logic [BITS-1:0] e_r;
  logic [BITS-1:0] n_r;
  logic [BITS-1:0] acc;
  logic [BITS-1:0] xbar;
  logic [BITS-1:0] mbar;
  logic [BITS-1:0] r2;
  logic [BITS-1:0] r_int;
  logic            err_int;
  logic [TW-1:0]   t;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;

  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic [TW-1:0]   t_add;
  logic [TW-1:0]   t_odd;
  logic [TW-1:0]   mp_step;
  logic [TW-1:0]   mp_fin;
  logic [BITS-1:0] mp_res;
  logic            mp_last;
  logic [BITS:0]   acc_dbl;
  logic [BITS:0]   acc_red;
  logic [BITS-1:0] acc_next;
  logic            accept;

  // Operand selection for the shared Montgomery product unit.
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state)
      S_MAP:   begin op_a = m_r;  op_b = r2;          end
      S_SQR:   begin op_a = xbar; op_b = xbar;        end
      S_MUL:   begin op_a = xbar; op_b = mbar;        end
      S_POST:  begin op_a = xbar; op_b = BITS'(1);    end
      default: begin op_a = '0;   op_b = '0;          end
    endcase
  end

  // One radix-2 MonPro step, the final conditional subtract, and PRE doubling.
  always_comb begin
    t_add    = t + (op_a[cnt[IW-1:0]] ? TW'(op_b) : TW'(0));
    t_odd    = t_add + (t_add[0] ? TW'(n_r) : TW'(0));
    mp_step  = t_odd >> 1;
    mp_fin   = (t >= TW'(n_r)) ? (t - TW'(n_r)) : t;
    mp_res   = BITS'(mp_fin);
    mp_last  = (cnt == CW'(BITS));
    acc_dbl  = {acc, 1'b0};
    acc_red  = (acc_dbl >= {1'b0, n_r}) ? (acc_dbl - {1'b0, n_r}) : acc_dbl;
    acc_next = BITS'(acc_red);
    accept   = START && !busy && ((state == S_IDLE) || (state == S_DONE));
  end

  // Control FSM and datapath registers; outputs are registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      m_r     <= '0;
      e_r     <= '0;
      n_r     <= '0;
      acc     <= '0;
      xbar    <= '0;
      mbar    <= '0;
      r2      <= '0;
      r_int   <= '0;
      err_int <= 1'b0;
      t       <= '0;
      cnt     <= '0;
      idx     <= '0;
      r       <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
        end

        S_CHK: begin
          cnt <= '0;
          t   <= '0;
          if (!n_r[0]) begin
            err_int <= 1'b1;
            r_int   <= '0;
            state   <= S_DONE;
          end else begin
            acc   <= BITS'(1);
            state <= S_PRE;
          end
        end

        S_PRE: begin
          acc <= acc_next;
          if (cnt == CW'(BITS - 1)) begin
            xbar <= acc_next;
          end
          if (cnt == CW'(2 * BITS - 1)) begin
            r2    <= acc_next;
            cnt   <= '0;
            t     <= '0;
            state <= S_MAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_MAP, S_SQR, S_MUL, S_POST: begin
          if (!mp_last) begin
            t   <= mp_step;
            cnt <= cnt + CW'(1);
          end else begin
            t   <= '0;
            cnt <= '0;
            unique case (state)
              S_MAP: begin
                mbar  <= mp_res;
                idx   <= IW'(BITS - 1);
                state <= S_SQR;
              end
              S_SQR: begin
                xbar <= mp_res;
                if (e_r[idx]) begin
                  state <= S_MUL;
                end else if (idx == '0) begin
                  state <= S_POST;
                end else begin
                  idx   <= idx - IW'(1);
                  state <= S_SQR;
                end
              end
              S_MUL: begin
                xbar <= mp_res;
                if (idx == '0) begin
                  state <= S_POST;
                end else begin
                  idx   <= idx - IW'(1);
                  state <= S_SQR;
                end
              end
              default: begin
                r_int <= mp_res;
                state <= S_DONE;
              end
            endcase
          end
        end

        S_DONE: begin
          r    <= r_int;
          done <= 1'b1;
          busy <= 1'b0;
          err  <= err_int;
        end

        default: state <= S_IDLE;
      endcase

      // A new operation captures operands and overrides the hold behaviour.
      if (accept) begin
        m_r     <= m;
        e_r     <= e;
        n_r     <= n;
        err_int <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b0;
        busy    <= 1'b1;
        cnt     <= '0;
        t       <= '0;
        state   <= S_CHK;
      end
    end
  end

endmodule

// File: tb/tb_modexp_engine.sv
// Scoreboard bench for modexp_engine: driver pushes expected result, err
// flag and latency; a monitor pops and compares on each rising done.
module tb_modexp_engine;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [63:0] m;
  logic [63:0] e;
  logic [63:0] n;
  logic [63:0] r;
  logic        done;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [63:0] res;
    logic        er;
    int          s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  logic done_q = 1'b0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  modexp_engine #(.BITS(64)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .m     (m),
    .e     (e),
    .n     (n),
    .r     (r),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  function automatic int lat_of(input logic [63:0] ev, input logic [63:0] nv);
    if (!nv[0]) return 2;
    return 2 + 2 * 64 + 65 * (64 + 2 + $countones(ev));
  endfunction

  // Plain square-and-multiply reference using wide arithmetic.
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] ex,
                                             input logic [63:0] md);
    logic [127:0] x;
    logic [127:0] bb;
    logic [127:0] mm;
    mm = {64'd0, md};
    x  = 128'd1 % mm;
    bb = {64'd0, b} % mm;
    for (int i = 63; i >= 0; i--) begin
      x = (x * x) % mm;
      if (ex[i]) x = (x * bb) % mm;
    end
    return x[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each completed operation against the scoreboard.
  always @(negedge CLK) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_x = sb.pop_front();
        chk("result", r, mon_x.res);
        chk("err_flag", 64'(err), 64'(mon_x.er));
        chk("latency", 64'(cyc - mon_x.s - 1), 64'(mon_x.lat));
      end
    end
    done_q = done;
  end

  task automatic issue(input logic [63:0] mv, input logic [63:0] ev, input logic [63:0] nv,
                       input logic [63:0] exp_r);
    @(negedge CLK);
    m     = mv;
    e     = ev;
    n     = nv;
    START = 1'b1;
    sb.push_back('{res: exp_r, er: !nv[0], s: cyc, lat: lat_of(ev, nv)});
    @(negedge CLK);
    START = 1'b0;
    m     = {$urandom, $urandom};
    e     = {$urandom, $urandom};
    n     = {$urandom, $urandom};
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 20000) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
      sb.delete();
    end
  endtask

  task automatic run(input logic [63:0] mv, input logic [63:0] ev, input logic [63:0] nv,
                     input logic [63:0] exp_r);
    issue(mv, ev, nv, exp_r);
    wait_done();
    repeat (3) @(negedge CLK);
    chk("done_hold", 64'(done), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] rm;
    logic [63:0] re;
    logic [63:0] rn;
    RESET = 1'b1;
    START = 1'b0;
    m = '0;
    e = '0;
    n = '0;
    repeat (3) @(negedge CLK);
    chk("reset_r", r, 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);

    // START together with RESET: reset wins.
    START = 1'b1;
    m = 64'd4;
    e = 64'd13;
    n = 64'd497;
    @(negedge CLK);
    START = 1'b0;
    RESET = 1'b0;
    chk("start_vs_reset", 64'(busy), 64'd0);
    @(negedge CLK);
    chk("start_vs_reset_idle", 64'(busy), 64'd0);

    run(64'd4, 64'd13, 64'd497, 64'd445);
    run(64'd5, 64'd0, 64'd497, 64'd1);
    run(64'd5, 64'd7, 64'd1, 64'd0);
    run(64'd0, 64'd9, 64'd497, 64'd0);
    run(64'd4, 64'd13, 64'h10, 64'd0);
    run(64'd4, 64'd13, 64'd497, 64'd445);
    run(64'd3, 64'd5, 64'd7, 64'd5);
    run(64'd1000, 64'd1, 64'd497, 64'd6);
    run(64'd2, 64'd10, 64'd1023, 64'd1);

    rm = '1;
    re = '1;
    rn = 64'hFFFF_FFFF_FFFF_FFC5;
    run(rm, re, rn, ref_modexp(rm, re, rn));
    for (int i = 0; i < 3; i++) begin
      rm = {$urandom, $urandom};
      re = {$urandom, $urandom};
      rn = {$urandom, $urandom} | 64'd1;
      run(rm, re, rn, ref_modexp(rm, re, rn));
    end

    // START pulsed mid-operation must be ignored.
    issue(64'd4, 64'd13, 64'd497, 64'd445);
    repeat (98) @(negedge CLK);
    m = 64'd7;
    e = 64'd1;
    n = 64'd11;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();
    repeat (3) @(negedge CLK);

    // RESET mid-operation aborts without a done.
    issue(64'd5, 64'd3, 64'd497, 64'd125);
    repeat (198) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_r", r, 64'd0);
    repeat (5) @(negedge CLK);
    chk("abort_no_done", 64'(done), 64'd0);
    run(64'd5, 64'd3, 64'd497, 64'd125);

    @(negedge CLK);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
